// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: next-PC source, forwarding select, result source and fetch FSM states.
package pipeline_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JALR   = 2'b10
  } pcsrc_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_hazard_ctrl_hazard_detect.sv
// Combinational load-use detection and execute-stage operand forwarding selects.
// Zero latency; raises loadUse for the top to turn into a fetch stall.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [1:0]                resultSrcE,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] rdE,
  input  logic [REG_ADDR_WIDTH-1:0] rdM,
  input  logic [REG_ADDR_WIDTH-1:0] rdW,
  input  logic                      regWriteM,
  input  logic                      regWriteW,
  output logic                      loadUse,
  output logic [1:0]                forwardAE,
  output logic [1:0]                forwardBE
);

  // Memory stage holds the younger value, so it wins over writeback.
  function automatic fwd_t fwdSel(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (regWriteM && (rdM != '0) && (rdM == rs)) return FWD_M;
    if (regWriteW && (rdW != '0) && (rdW == rs)) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    loadUse   = (resultSrcE == RESULT_SRC_MEM) && (rdE != '0) &&
                ((rdE == rs1D) || (rdE == rs2D));
    forwardAE = fwdSel(rs1E);
    forwardBE = fwdSel(rs2E);
  end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch controller: PC register, boot FSM, next-PC select and pipeline-register strobes; strobes are same-cycle, PC one edge later.
// Load-use stalls hold PC and fetch reg, redirects flush both; FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                PCSrcE_i,
  input  logic [DATA_WIDTH-1:0]     PCTargetE_i,
  input  logic [DATA_WIDTH-1:0]     ALUResultE_i,
  input  logic [1:0]                ResultSrcE_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      RegWriteM_i,
  input  logic                      RegWriteW_i,
  output logic [DATA_WIDTH-1:0]     PCF_o,
  output logic [DATA_WIDTH-1:0]     PCPlus4F_o,
  output logic                      Fen_o,
  output logic                      Frst_o,
  output logic                      Den_o,
  output logic                      Drst_o,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               StallCount_o,
  output logic [31:0]               FlushCount_o
`endif
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pcReg;
  logic [DATA_WIDTH-1:0] pcPlus4;
  logic [DATA_WIDTH-1:0] pcNext;
  logic                  loadUse;
  logic                  redirect;
  logic                  stall;

  hazard_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .resultSrcE(ResultSrcE_i),
    .rs1D      (Rs1D_i),
    .rs2D      (Rs2D_i),
    .rs1E      (Rs1E_i),
    .rs2E      (Rs2E_i),
    .rdE       (RdE_i),
    .rdM       (RdM_i),
    .rdW       (RdW_i),
    .regWriteM (RegWriteM_i),
    .regWriteW (RegWriteW_i),
    .loadUse   (loadUse),
    .forwardAE (ForwardAE_o),
    .forwardBE (ForwardBE_o)
  );

  assign pcPlus4  = pcReg + DATA_WIDTH'(4);
  assign redirect = (state == RUN) &&
                    ((PCSrcE_i == PCSRC_BRANCH) || (PCSrcE_i == PCSRC_JALR));
  // A redirect squashes the stalled instruction, so it overrides the stall.
  assign stall    = (state == RUN) && loadUse && !redirect;

  always_comb begin
    pcNext = pcPlus4;
    if (state == BOOT)                  pcNext = RESET_PC;
    else if (PCSrcE_i == PCSRC_BRANCH)  pcNext = PCTargetE_i;
    else if (PCSrcE_i == PCSRC_JALR)    pcNext = ALUResultE_i & ~DATA_WIDTH'(1);
    else if (loadUse)                   pcNext = pcReg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pcReg <= RESET_PC;
    end else begin
      state <= RUN;
      pcReg <= pcNext;
    end
  end

  assign PCF_o      = pcReg;
  assign PCPlus4F_o = pcPlus4;
  assign Fen_o      = !stall;
  assign Frst_o     = (state == BOOT) || redirect;
  assign Drst_o     = (state == BOOT) || redirect || loadUse;
  assign Den_o      = 1'b1;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount_o <= '0;
      FlushCount_o <= '0;
    end else begin
      if (stall && (StallCount_o != '1))    StallCount_o <= StallCount_o + 32'd1;
      if (redirect && (FlushCount_o != '1)) FlushCount_o <= FlushCount_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Fetch-stage controller directly upstream of the pipelined control/decode top. It owns the program counter, selects the next PC from the execute-stage redirect code, detects load-use and control hazards, and drives the enable/clear strobes of the fetch→decode and decode→execute pipeline registers plus the execute-stage forwarding selects. A two-state boot FSM guarantees a clean bubble after reset.

## Interface
- DATA_WIDTH, 32, PC and datapath width
- RESET_PC, 32'h0, PC value loaded on reset
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- PCSrcE_i  in  2  00 PC+4, 01 branch/JAL target, 10 JALR target
- PCTargetE_i  in  DATA_WIDTH  PCE + immediate
- ALUResultE_i  in  DATA_WIDTH  JALR target (rs1 + imm)
- ResultSrcE_i  in  2  execute result source; 01 = load
- Rs1D_i, Rs2D_i  in  REG_ADDR_WIDTH  decode source registers
- Rs1E_i, Rs2E_i, RdE_i  in  REG_ADDR_WIDTH  execute registers
- RdM_i, RdW_i  in  REG_ADDR_WIDTH  memory/writeback destinations
- RegWriteM_i, RegWriteW_i  in  1  write-enable in M/W
- PCF_o  out  DATA_WIDTH  current fetch PC
- PCPlus4F_o  out  DATA_WIDTH  PCF_o + 4
- Fen_o, Frst_o  out  1  fetch→decode register enable / synchronous clear
- Den_o, Drst_o  out  1  decode→execute register enable / synchronous clear
- ForwardAE_o, ForwardBE_o  out  2  00 register file, 01 writeback, 10 memory

## Operation
- FSM states BOOT, RUN. Reset enters BOOT; BOOT→RUN unconditionally on next edge; RUN holds until reset.
- BOOT: PC holds RESET_PC, Frst_o=1, Drst_o=1, Fen_o=1, Den_o=1.
- RUN next-PC priority: (1) PCSrcE_i=01 → PCTargetE_i; (2) PCSrcE_i=10 → ALUResultE_i with bit 0 forced 0; (3) load-use stall → hold PC; (4) else PC+4. PCSrcE_i=11 treated as 00.
- Load-use stall: ResultSrcE_i=01 and RdE_i≠0 and (RdE_i==Rs1D_i or RdE_i==Rs2D_i). Drives Fen_o=0, Drst_o=1, PC hold.
- Redirect (PCSrcE_i≠00): Frst_o=1, Drst_o=1, Fen_o=1. Redirect beats stall when both true.
- Den_o is constant 1 outside reset; execute never stalls.
- Forward A: 10 if RegWriteM_i & RdM_i≠0 & RdM_i==Rs1E_i; else 01 if RegWriteW_i & RdW_i≠0 & RdW_i==Rs1E_i; else 00. B identical on Rs2E_i. M has priority over W.
- PC arithmetic modulo 2^DATA_WIDTH; PC+4 from all-ones-minus-3 wraps to 0.

## Timing
- Reset values: PCF_o=RESET_PC, PCPlus4F_o=RESET_PC+4, Frst_o=1, Drst_o=1, Fen_o=1, Den_o=1, Forward*=00 (combinational from inputs), state BOOT.
- PC register updates on rising edge; PCF_o changes one cycle after the redirect/stall condition is sampled.
- Fen/Frst/Den/Drst/Forward* are combinational from current state and inputs, valid same cycle.
- Redirect penalty: 2 bubbles. Load-use penalty: 1 bubble.
- rst_n assertion mid-operation: PC and FSM reset immediately (asynchronous), outputs take reset values without waiting for clk.

## Configuration
- FETCH_PERF_EN defined: adds outputs StallCount_o and FlushCount_o (32 b each, reset 0), incrementing once per RUN cycle with load-use stall (not overridden by redirect) and once per redirect cycle respectively; saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package pipeline_pkg: pcsrc_t (PCSRC_PLUS4=00, PCSRC_BRANCH=01, PCSRC_JALR=10), fwd_t (FWD_RF, FWD_W, FWD_M), RESULT_SRC_MEM=2'b01, fetch_state_t (BOOT, RUN).
- One sub-module, hazard_detect: purely combinational stall/forward logic; top holds PC register, FSM and counters.

## Test plan
- Release rst_n → cycle 0 BOOT: PCF_o=0, Frst_o=1, Drst_o=1; cycle 1 RUN: PCF_o=4 next edge, Frst_o=0.
- RUN, PCSrcE_i=01, PCTargetE_i=0x100 → Frst_o=Drst_o=1 same cycle, PCF_o=0x100 next cycle.
- PCSrcE_i=10, ALUResultE_i=0x203 → PCF_o=0x202 next cycle.
- ResultSrcE_i=01, RdE_i=5, Rs2D_i=5 → Fen_o=0, Drst_o=1, PCF_o unchanged; RdE_i=0 → no stall.
- Same load-use plus PCSrcE_i=01 → redirect wins: Fen_o=1, PCF_o=target.
- RdM_i=RdW_i=Rs1E_i=7, both writes → ForwardAE_o=10; RegWriteM_i=0 → 01; Rs1E_i=0 → 00.
